output_decoding: RTL and testbench

OUTPUT_DECODING -- requirements
Module: output_decoding

---
 rtl/output_decoding.sv | 84 ++++++++
 tb/tb_output_decoding.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/output_decoding.sv
// Output decoding for the sign/magnitude multiplier. This is a 2-stage elastic pipeline
// that turns an unsigned product magnitude plus the XOR of the operand signs into a two's-complement result.
module output_decoding #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_MAG = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mag_in,
  input  logic             sign_a,
  input  logic             sign_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] prod_out,
  output logic             err
);

  localparam logic [WIDTH:0] MAX_MAG_W = (WIDTH+1)'(MAX_MAG);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_mag;
  logic             s1_sign;
  logic             s1_illegal;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_prod;
  logic             s2_err;

  logic             s2_can_load;
  logic             s1_to_s2;
  logic             in_xfer;
  logic [WIDTH-1:0] dec_prod;

  // in_ready depends on out_ready and stage occupancy only, never on in_valid
  assign s2_can_load = !s2_valid || out_ready;
  assign s1_to_s2    = s1_valid && s2_can_load;
  assign in_ready    = !s1_valid || s2_can_load;
  assign in_xfer     = in_valid && in_ready;

  // Ones-complement with the sign as carry-in; a zero magnitude therefore never becomes negative zero
  always_comb begin
    dec_prod = '0;
    if (!s1_illegal) begin
      dec_prod = (s1_mag ^ {WIDTH{s1_sign}}) + WIDTH'(s1_sign);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_mag     <= '0;
      s1_sign    <= 1'b0;
      s1_illegal <= 1'b0;
    end else if (in_xfer) begin
      s1_valid   <= 1'b1;
      s1_mag     <= mag_in;
      s1_sign    <= sign_a ^ sign_b;
      s1_illegal <= ({1'b0, mag_in} > MAX_MAG_W);
    end else if (s1_to_s2) begin
      s1_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_err   <= 1'b0;
    end else if (s2_can_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod <= dec_prod;
        s2_err  <= s1_illegal;
      end
    end
  end

  assign out_valid = s2_valid;
  assign prod_out  = s2_prod;
  assign err       = s2_err;

endmodule

// File: tb/tb_output_decoding.sv
// Directed testbench for output_decoding. It drives hand-computed vectors and uses immediate-assertion checks.
module tb_output_decoding;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] mag_in;
  logic             sign_a;
  logic             sign_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] prod_out;
  logic             err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  output_decoding #(.WIDTH(WIDTH), .MAX_MAG(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .mag_in(mag_in), .sign_a(sign_a), .sign_b(sign_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .prod_out(prod_out), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] m, input logic sa, input logic sb);
    in_valid = 1'b1;
    mag_in   = m;
    sign_a   = sa;
    sign_b   = sb;
  endtask

  task automatic out_chk(input string tag, input logic [WIDTH-1:0] p, input logic e);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_prod"}, 32'(prod_out), 32'(p));
    chk({tag, "_err"}, 32'(err), 32'(e));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mag_in = '0; sign_a = 1'b0; sign_b = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_prod", 32'(prod_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step(); step();
    rst_n = 1'b1;

    // -21: accepted on the first edge after reset release, visible after the next
    send(8'd21, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    step();
    out_chk("neg21", 8'hEB, 1'b0);
    step();
    chk("neg21_drain", 32'(out_valid), 32'd0);

    // sign combinations and zero magnitude, streamed
    send(8'd64, 1'b1, 1'b1);
    step();
    send(8'd64, 1'b0, 1'b1);
    step();
    out_chk("pos64", 8'h40, 1'b0);
    send(8'd0, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    out_chk("neg64", 8'hC0, 1'b0);
    step();
    out_chk("negzero", 8'h00, 1'b0);
    step();
    chk("sign_drain", 32'(out_valid), 32'd0);

    // back-to-back negatives without bubbles
    send(8'd3, 1'b1, 1'b0);
    step();
    send(8'd5, 1'b0, 1'b1);
    step();
    out_chk("b2b_3", 8'hFD, 1'b0);
    send(8'd7, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    out_chk("b2b_5", 8'hFB, 1'b0);
    step();
    out_chk("b2b_7", 8'hF9, 1'b0);
    step();
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // backpressure: two buffered results, then release
    out_ready = 1'b0;
    send(8'd9, 1'b0, 1'b0);
    step();
    chk("bp_ready_one", 32'(in_ready), 32'd1);
    send(8'd10, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    out_chk("bp_hold9", 8'h09, 1'b0);
    step();
    chk("bp_still_full", 32'(in_ready), 32'd0);
    out_chk("bp_stable9", 8'h09, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(in_ready), 32'd1);
    step();
    out_chk("bp_deliver10", 8'h0A, 1'b0);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // simultaneous in/out transfer with both stages full
    out_ready = 1'b0;
    send(8'd20, 1'b0, 1'b0);
    step();
    send(8'd21, 1'b0, 1'b0);
    step();
    send(8'd22, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    out_chk("sim_20", 8'h14, 1'b0);
    step();
    in_valid = 1'b0;
    out_chk("sim_21", 8'h15, 1'b0);
    step();
    out_chk("sim_22", 8'h16, 1'b0);
    step();
    chk("sim_drain", 32'(out_valid), 32'd0);

    // illegal magnitude, followed by a legal one
    send(8'd65, 1'b1, 1'b0);
    step();
    send(8'd30, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    out_chk("illegal65", 8'h00, 1'b1);
    step();
    out_chk("legal_after", 8'hE2, 1'b0);
    step();

    // asynchronous reset with two buffered results
    out_ready = 1'b0;
    send(8'd1, 1'b0, 1'b0);
    step();
    send(8'd2, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_prod", 32'(prod_out), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    step();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("ar_no_stale1", 32'(out_valid), 32'd0);
    step();
    chk("ar_no_stale2", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
